// File: rtl/multi_chan_syncer.sv
// Multi-channel async-input conditioner: N-stage synchroniser, stability filter and
// per-channel selectable edge detector with a sticky event flag, all in the clk_i domain.

module mcs_chan #(
  parameter int   SYNC_STAGES = 2,
  parameter int   FILTER_LEN  = 3,
  parameter int   CNT_W       = 2,
  parameter logic RST_BIT     = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       din,
  input  logic [1:0] mode,
  input  logic       clr,
  output logic       level,
  output logic       pulse,
  output logic       evt_flag
);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILTER_LEN - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CNT_W-1:0]       cnt;
  logic                   sync;
  logic                   upd;
  logic                   hit;

  assign sync = sync_q[SYNC_STAGES-1];
  assign upd  = (sync != level) && (cnt == CNT_MAX);
  // sync is the new level on an update edge, so sync=1 means a rising edge
  assign hit  = upd && (sync ? mode[0] : mode[1]);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q   <= {SYNC_STAGES{RST_BIT}};
      level    <= RST_BIT;
      cnt      <= '0;
      pulse    <= 1'b0;
      evt_flag <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      if (sync == level) begin
        cnt <= '0;
      end else if (upd) begin
        level <= sync;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
      pulse <= hit;
      if (hit)      evt_flag <= 1'b1;
      else if (clr) evt_flag <= 1'b0;
    end
  end
endmodule

module multi_chan_syncer #(
  parameter int                  CHAN_NUM    = 4,
  parameter int                  SYNC_STAGES = 2,
  parameter int                  FILTER_LEN  = 3,
  parameter int                  CNT_W       = 2,
  parameter logic [CHAN_NUM-1:0] RST_VAL     = {CHAN_NUM{1'b0}},
  parameter int                  DLY         = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic [CHAN_NUM-1:0]   data_unsync_i,
  input  logic [2*CHAN_NUM-1:0] edge_mode_i,
  input  logic [CHAN_NUM-1:0]   evt_clr_i,
  output logic [CHAN_NUM-1:0]   level_o,
  output logic [CHAN_NUM-1:0]   pulse_o,
  output logic [CHAN_NUM-1:0]   evt_flag_o
);
  // The filter counter must reach FILTER_LEN-1 without wrapping.
  if ((2**CNT_W) < FILTER_LEN || SYNC_STAGES < 2 || FILTER_LEN < 1 || CHAN_NUM < 1 || DLY < 0)
  begin : g_bad_cfg
    $error("multi_chan_syncer: illegal parameter combination");
  end

  logic [CHAN_NUM-1:0][1:0] mode;
  assign mode = edge_mode_i;

  for (genvar k = 0; k < CHAN_NUM; k++) begin : g_chan
    mcs_chan #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILTER_LEN  (FILTER_LEN),
      .CNT_W       (CNT_W),
      .RST_BIT     (RST_VAL[k])
    ) u_chan (
      .clk      (clk_i),
      .rst_n    (rst_n_i),
      .din      (data_unsync_i[k]),
      .mode     (mode[k]),
      .clr      (evt_clr_i[k]),
      .level    (level_o[k]),
      .pulse    (pulse_o[k]),
      .evt_flag (evt_flag_o[k])
    );
  end
endmodule
